// File: rtl/mem_responder.sv
// Word-organised SRAM responder on the CPU bus with byte/halfword/word lanes,
// a programmable wait-state count, and a one-cycle error pulse on misaligned accesses.
module mem_responder #(
  parameter int width       = 32,
  parameter int depth_log2  = 10,
  parameter int wait_cycles = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] AddrOut,
  input  logic [width-1:0] DataOut,
  input  logic             we,
  input  logic             re,
  input  logic [1:0]       sel,
  output logic [width-1:0] DataIn,
  output logic             mdelay,
  output logic             err
);

  localparam int         DEPTH = 1 << depth_log2;
  localparam logic [3:0] WAITS = 4'(wait_cycles);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [width-1:0]      r_addr;
  logic                  r_we;
  logic                  r_re;
  logic [1:0]            r_sel;
  logic                  r_err;
  logic [width-1:0]      r_mem [DEPTH];

  logic                  w_req;
  logic                  w_new;
  logic                  w_mdelay;
  logic                  w_done;
  logic                  w_mis;
  logic                  w_wr_en;
  logic [depth_log2-1:0] w_idx;
  logic [width-1:0]      w_word;
  logic [width-1:0]      w_rdata;
  logic [width-1:0]      w_wdata;
  logic [3:0]            w_be;

  assign w_req  = we | re;
  assign w_idx  = AddrOut[depth_log2+1:2];
  assign w_word = r_mem[w_idx];

  // Request decode: new-command detection, wait handshake and completion.
  always_comb begin
    w_new    = 1'b0;
    w_mdelay = 1'b0;
    w_mis    = 1'b0;
    if ((r_state == ST_IDLE) || (AddrOut != r_addr) || (we != r_we) ||
        (re != r_re) || (sel != r_sel)) begin
      w_new = 1'b1;
    end else begin
      w_new = 1'b0;
    end
    // Reset forces the bus quiet; zero wait states never stall the CPU.
    if (rst && w_req && (WAITS != 4'd0)) begin
      w_mdelay = w_new || (r_cnt != WAITS);
    end else begin
      w_mdelay = 1'b0;
    end
    if (sel == 2'b01) begin
      w_mis = AddrOut[0];
    end else if (sel[1]) begin
      w_mis = (AddrOut[1:0] != 2'b00);
    end else begin
      w_mis = 1'b0;
    end
    w_done  = rst && w_req && !w_mdelay;
    w_wr_en = w_done && we && !w_mis;
  end

  // Lane steering for read data (right-justified, zero-extended) and write data/enables.
  always_comb begin
    w_rdata = {width{1'b0}};
    w_wdata = DataOut;
    w_be    = 4'b0000;
    case (sel)
      2'b00: begin
        w_wdata = {(width/8){DataOut[7:0]}};
        w_be    = 4'b0001 << AddrOut[1:0];
        w_rdata = {{(width-8){1'b0}}, w_word[{AddrOut[1:0], 3'b000} +: 8]};
      end
      2'b01: begin
        w_wdata = {(width/16){DataOut[15:0]}};
        w_be    = AddrOut[1] ? 4'b1100 : 4'b0011;
        w_rdata = {{(width-16){1'b0}}, w_word[{AddrOut[1], 4'b0000} +: 16]};
      end
      default: begin
        w_wdata = DataOut;
        w_be    = 4'b1111;
        w_rdata = w_word;
      end
    endcase
    if (!(w_done && !w_mis)) begin
      w_rdata = {width{1'b0}};
    end else begin
      w_rdata = w_rdata;
    end
  end

  assign DataIn = w_rdata;
  assign mdelay = w_mdelay;
  assign err    = r_err;

  // Wait-state sequencer: latches the command and counts toward completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= {width{1'b0}};
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_sel   <= 2'b00;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_done && w_mis;
      if (!w_req) begin
        r_state <= ST_IDLE;
        r_cnt   <= 4'd0;
      end else if (w_new) begin
        r_addr <= AddrOut;
        r_we   <= we;
        r_re   <= re;
        r_sel  <= sel;
        if (WAITS == 4'd0) begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end else begin
          r_state <= ST_WAIT;
          r_cnt   <= 4'd1;
        end
      end else if (r_cnt != WAITS) begin
        r_cnt <= r_cnt + 4'd1;
      end else begin
        // Completion: a still-held request is treated as a fresh access.
        r_state <= ST_IDLE;
        r_cnt   <= 4'd0;
      end
    end
  end

  // Array write: only the selected lanes, only at the end of a completing aligned write.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_wr_en && w_be[b]) begin
        r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a byte-addressed reference memory plus an
// access-age timing model checked every cycle, and directed accesses with literal expectations.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_a [2];
  logic [31:0] dout_a [2];
  logic [31:0] din_a  [2];
  logic        we_a   [2];
  logic        re_a   [2];
  logic [1:0]  sel_a  [2];
  logic        md_a   [2];
  logic        err_a  [2];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit [7:0]    mm   [2][4096];
  bit          kn   [2][4096];
  int          age  [2];
  bit          pv   [2];
  logic [35:0] pcmd [2];
  bit          err_exp [2];

  always #5 clk = ~clk;

  mem_responder #(.width(32), .depth_log2(10), .wait_cycles(2)) u0 (
    .clk(clk), .rst(rst), .AddrOut(addr_a[0]), .DataOut(dout_a[0]), .we(we_a[0]),
    .re(re_a[0]), .sel(sel_a[0]), .DataIn(din_a[0]), .mdelay(md_a[0]), .err(err_a[0]));

  mem_responder #(.width(32), .depth_log2(4), .wait_cycles(0)) u1 (
    .clk(clk), .rst(rst), .AddrOut(addr_a[1]), .DataOut(dout_a[1]), .we(we_a[1]),
    .re(re_a[1]), .sel(sel_a[1]), .DataIn(din_a[1]), .mdelay(md_a[1]), .err(err_a[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int nw(int d);
    return (d == 0) ? 1024 : 16;
  endfunction

  function automatic int wt(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int nbytes(int d);
    return (sel_a[d] == 2'b00) ? 1 : (sel_a[d] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit misal(int d);
    int off = int'(addr_a[d] % 4);
    return ((nbytes(d) == 2) && (off % 2 != 0)) || ((nbytes(d) == 4) && (off != 0));
  endfunction

  // Cycles the current command has been held unchanged, 0 on its first cycle.
  function automatic int cur_age(int d);
    if ((we_a[d] || re_a[d]) && pv[d] &&
        ({addr_a[d], we_a[d], re_a[d], sel_a[d]} === pcmd[d]))
      return age[d] + 1;
    return 0;
  endfunction

  function automatic bit is_done(int d);
    return rst && (we_a[d] || re_a[d]) && ((cur_age(d) % (wt(d) + 1)) == wt(d));
  endfunction

  function automatic int byte_idx(int d, int k);
    int wi = int'((addr_a[d] / 4) % nw(d));
    return wi * 4 + int'(addr_a[d] % 4) + k;
  endfunction

  // {known, value}: expected read data assembled byte by byte from the model memory.
  function automatic logic [32:0] exp_rd(int d);
    logic [31:0] v = 32'h0;
    if (misal(d)) return {1'b1, 32'h0};
    for (int k = 0; k < nbytes(d); k++) begin
      if (!kn[d][byte_idx(d, k)]) return {1'b0, 32'h0};
      v = v | (32'(mm[d][byte_idx(d, k)]) << (8 * k));
    end
    return {1'b1, v};
  endfunction

  // Per-cycle comparison of both DUTs against the model, away from the active edge.
  always @(negedge clk) begin
    logic [32:0] e;
    bit          dn;
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        chk($sformatf("dut%0d_rst_mdelay", d), {31'h0, md_a[d]}, 32'h0);
        chk($sformatf("dut%0d_rst_datain", d), din_a[d], 32'h0);
        chk($sformatf("dut%0d_rst_err", d), {31'h0, err_a[d]}, 32'h0);
      end else begin
        dn = is_done(d);
        chk($sformatf("dut%0d_mdelay", d), {31'h0, md_a[d]},
            {31'h0, (we_a[d] || re_a[d]) && !dn});
        chk($sformatf("dut%0d_err", d), {31'h0, err_a[d]}, {31'h0, err_exp[d]});
        if (dn) begin
          e = exp_rd(d);
          if (e[32]) chk($sformatf("dut%0d_datain", d), din_a[d], e[31:0]);
        end else begin
          chk($sformatf("dut%0d_datain_idle", d), din_a[d], 32'h0);
        end
      end
    end
  end

  // Model update on the active edge.
  always @(posedge clk) begin
    int a;
    bit dn;
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        pv[d] = 1'b0; age[d] = 0; err_exp[d] = 1'b0;
      end else begin
        a  = cur_age(d);
        dn = is_done(d);
        if (dn && we_a[d] && !misal(d)) begin
          for (int k = 0; k < nbytes(d); k++) begin
            mm[d][byte_idx(d, k)] = 8'(dout_a[d] >> (8 * k));
            kn[d][byte_idx(d, k)] = 1'b1;
          end
        end
        err_exp[d] = dn && misal(d);
        pv[d]      = we_a[d] || re_a[d];
        pcmd[d]    = {addr_a[d], we_a[d], re_a[d], sel_a[d]};
        age[d]     = a;
      end
    end
  end

  // Wait for completion of the currently driven request, then release it.
  task automatic hold(input int d, output int waits, output logic [31:0] rd, output logic e);
    waits = 0;
    @(negedge clk);
    while (md_a[d] && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 40) begin
      checks++; errors++;
      $display("FAIL dut%0d_timeout got %0d want <40", d, waits);
    end
    rd = din_a[d];
    @(posedge clk); #1;
    we_a[d] = 1'b0; re_a[d] = 1'b0;
    @(negedge clk);
    e = err_a[d];
  endtask

  task automatic drive(input int d, input logic [31:0] a, dat, input logic w, r,
                       input logic [1:0] s);
    addr_a[d] = a; dout_a[d] = dat; we_a[d] = w; re_a[d] = r; sel_a[d] = s;
  endtask

  task automatic run(input string nm, input int d, input logic [31:0] a, dat,
                     input logic w, r, input logic [1:0] s, input int exp_waits,
                     input logic [31:0] exp_rd_v, input bit chk_rd, input logic exp_err);
    int waits; logic [31:0] rd; logic e;
    @(posedge clk); #1;
    drive(d, a, dat, w, r, s);
    hold(d, waits, rd, e);
    chk({nm, "_waits"}, 32'(waits), 32'(exp_waits));
    if (chk_rd) chk({nm, "_data"}, rd, exp_rd_v);
    chk({nm, "_err"}, {31'h0, e}, {31'h0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits; logic [31:0] rd; logic e;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) drive(d, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
    #2 rst = 1'b0;
    drive(0, 32'h10, 32'h0, 1'b1, 1'b0, 2'b10);
    repeat (2) @(negedge clk);
    chk("reset_mdelay", {31'h0, md_a[0]}, 32'h0);
    chk("reset_err", {31'h0, err_a[0]}, 32'h0);
    chk("reset_datain", din_a[0], 32'h0);
    @(posedge clk); #1;
    drive(0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
    rst = 1'b1;

    run("wr_beef", 0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 2'b10, 2, 32'h0, 1'b0, 1'b0);
    run("rd_beef", 0, 32'h10, 32'h0, 1'b0, 1'b1, 2'b10, 2, 32'hDEADBEEF, 1'b1, 1'b0);
    run("wr_1122", 0, 32'h10, 32'h11223344, 1'b1, 1'b0, 2'b10, 2, 32'h0, 1'b0, 1'b0);
    run("wr_byte", 0, 32'h13, 32'h000000AA, 1'b1, 1'b0, 2'b00, 2, 32'h0, 1'b0, 1'b0);
    run("rd_word", 0, 32'h10, 32'h0, 1'b0, 1'b1, 2'b10, 2, 32'hAA223344, 1'b1, 1'b0);
    run("rd_half", 0, 32'h12, 32'h0, 1'b0, 1'b1, 2'b01, 2, 32'h0000AA22, 1'b1, 1'b0);
    run("rd_byte", 0, 32'h11, 32'h0, 1'b0, 1'b1, 2'b00, 2, 32'h00000033, 1'b1, 1'b0);

    // Mid-wait switch from a read of 0x20 to a byte write at 0x24.
    run("wr_20", 0, 32'h20, 32'hCAFEF00D, 1'b1, 1'b0, 2'b10, 2, 32'h0, 1'b0, 1'b0);
    run("wr_24", 0, 32'h24, 32'h00000000, 1'b1, 1'b0, 2'b10, 2, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 32'h20, 32'h0, 1'b0, 1'b1, 2'b10);
    @(negedge clk);
    chk("mid_first_mdelay", {31'h0, md_a[0]}, 32'h1);
    @(posedge clk); #1;
    drive(0, 32'h24, 32'h00000055, 1'b1, 1'b0, 2'b00);
    hold(0, waits, rd, e);
    chk("mid_waits", 32'(waits), 32'd2);
    run("rd_20", 0, 32'h20, 32'h0, 1'b0, 1'b1, 2'b10, 2, 32'hCAFEF00D, 1'b1, 1'b0);
    run("rd_24", 0, 32'h24, 32'h0, 1'b0, 1'b1, 2'b10, 2, 32'h00000055, 1'b1, 1'b0);

    // Misaligned word write.
    run("wr_04", 0, 32'h04, 32'h12345678, 1'b1, 1'b0, 2'b10, 2, 32'h0, 1'b0, 1'b0);
    run("mis_wr", 0, 32'h06, 32'hFFFFFFFF, 1'b1, 1'b0, 2'b10, 2, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    chk("mis_err_one_cycle", {31'h0, err_a[0]}, 32'h0);
    run("rd_04", 0, 32'h04, 32'h0, 1'b0, 1'b1, 2'b10, 2, 32'h12345678, 1'b1, 1'b0);

    // Simultaneous write+read returns pre-write contents; sel=11 acts as word.
    run("wr_40", 0, 32'h40, 32'h01020304, 1'b1, 1'b0, 2'b10, 2, 32'h0, 1'b0, 1'b0);
    run("wrrd_40", 0, 32'h40, 32'h00000099, 1'b1, 1'b1, 2'b11, 2, 32'h01020304, 1'b1, 1'b0);
    run("rd_40", 0, 32'h40, 32'h0, 1'b0, 1'b1, 2'b10, 2, 32'h00000099, 1'b1, 1'b0);

    // Reset asserted in the middle of a write's wait.
    run("wr_30", 0, 32'h30, 32'h00000000, 1'b1, 1'b0, 2'b10, 2, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 32'h30, 32'hA5A5A5A5, 1'b1, 1'b0, 2'b10);
    @(negedge clk);
    chk("rst_pre_mdelay", {31'h0, md_a[0]}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_mdelay", {31'h0, md_a[0]}, 32'h0);
    chk("rst_mid_cnt", {28'h0, u0.r_cnt}, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    hold(0, waits, rd, e);
    chk("rst_restart_waits", 32'(waits), 32'd2);
    run("rd_30", 0, 32'h30, 32'h0, 1'b0, 1'b1, 2'b10, 2, 32'hA5A5A5A5, 1'b1, 1'b0);

    // Zero wait states with a 16-word array: 0x40 aliases word 0.
    run("z_wr40", 1, 32'h40, 32'h0BADCAFE, 1'b1, 1'b0, 2'b10, 0, 32'h0, 1'b0, 1'b0);
    run("z_rd00", 1, 32'h00, 32'h0, 1'b0, 1'b1, 2'b10, 0, 32'h0BADCAFE, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU data/instruction bus: services reads and writes issued through the bus arbiter.
- Drives the data returned to the CPU and the mdelay wait signal back to the CPU.
- Contains a word-organised SRAM array with byte, halfword and word lanes and a programmable number of wait states.
- Sits at top level beside cpu, wired port-for-port to the CPU bus.

Parameters:
- width, 32: bus data/address width.
- depth_log2, 10: log2 of array depth in 32-bit words; array = 2^depth_log2 words.
- wait_cycles, 2: wait states per access, legal range 0..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- AddrOut  input  width  byte address from CPU
- DataOut  input  width  write data from CPU, right-justified
- we  input  1  write request
- re  input  1  read request
- sel  input  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word
- DataIn  output  width  read data to CPU, right-justified and zero-extended
- mdelay  output  1  high = access not complete; CPU holds request stable
- err  output  1  one-cycle pulse after a misaligned access completes

Behaviour:
- req = we | re. If we and re are both high, the access is a write; DataIn still returns the pre-write contents.
- Registers:
  - cnt, 4 bits.
  - Latched command {AddrOut, we, re, sel}.
  - err.
- Reset (rst low, asynchronous): cnt=0, latched command=0, err=0. Array contents are not cleared.
- While reset is asserted, mdelay=0 and DataIn=0.
- States:
  - IDLE: cnt=0, no access pending.
  - WAIT: 0 < cnt <= wait_cycles.
- mdelay = req & (new command | cnt != wait_cycles), combinational.
  - new command = state IDLE, or current {AddrOut, we, re, sel} differs from the latched copy.
  - With wait_cycles=0, mdelay is always 0.
- Latency: a request first presented in cycle 0 and held stable sees mdelay high in cycles 0..wait_cycles-1 and low in cycle wait_cycles. The access completes in that cycle.
- Sequential update on each clk edge:
  - !req: cnt <= 0 (IDLE). A pending access is abandoned with no side effects.
  - req and new command: latch command; cnt <= 1; stay in WAIT. If wait_cycles=0, the access completes this cycle and cnt stays 0.
  - req, same command, cnt < wait_cycles: cnt <= cnt+1.
  - req, same command, cnt == wait_cycles (completion): cnt <= 0, so a held request restarts as a new access next cycle.
    - The CPU must drop or change the request after completion.
- Mid-wait command change (e.g. arbiter switches from fetch to memory stage): the count restarts at 1 and mdelay stays high. No write is performed for the abandoned command.
- Addressing: word index = AddrOut[depth_log2+1:2]. Upper address bits are ignored, so addresses alias/wrap modulo the array size.
- Byte lanes are little-endian:
  - Byte uses lane AddrOut[1:0].
  - Halfword uses lanes {AddrOut[1],1} and {AddrOut[1],0}.
- Write commit: on the clk edge ending the completion cycle, only the selected lanes are written. No write occurs on any other cycle.
- Read data: DataIn is valid in the completion cycle.
  - It is the combinational array read of the indexed word, lane-shifted to bit 0 and zero-extended per sel.
  - Outside the completion cycle DataIn is don't-care; the implementation drives 0.
- Misalignment: halfword with AddrOut[0]=1, or word with AddrOut[1:0]!=0.
  - The access still takes the full wait count.
  - No write is performed; DataIn=0 in the completion cycle.
  - err pulses high for exactly one cycle after completion.
  - Aligned accesses leave err=0.
- Reset asserted mid-wait: cnt clears immediately; no write; the access restarts after reset is released.

Test Plan:
- Word write/read, wait_cycles=2:
  - Write 0xDEADBEEF to 0x10 -> mdelay high 2 cycles, low on the 3rd; array word 4 is updated.
  - Read 0x10 -> DataIn=0xDEADBEEF in the cycle mdelay falls.
- Sub-word lanes:
  - Byte write 0xAA at 0x13 into word 0x11223344 -> reads back 0xAA223344 as a word.
  - Halfword read at 0x12 -> 0x0000AA22.
  - Byte read at 0x11 -> 0x00000033.
- Mid-wait change: read 0x20, then after 1 cycle switch to a write of 0x55 at 0x24 -> mdelay stays high for 2 more cycles; only word 9 is written; 0x20 is unaffected.
- Misaligned: word write 0xFFFFFFFF to 0x06 -> completes after 2 waits; array unchanged; err high exactly 1 cycle afterwards.
- Zero-wait and wrap, wait_cycles=0, depth_log2=4:
  - Write to 0x40 -> mdelay never high; word 0 is written (alias).
  - Read 0x00 -> returns the written data.
- Async reset: drop rst mid-wait of a write -> cnt=0 and mdelay=0 immediately; word unchanged; after release the same request completes after 2 waits.
